// File: rtl/video_pkg.sv
// Shared video-path definitions for the screen compositor.
//   fade_state_t : fade sequencer states
//   LVL_W        : brightness level width
//   LVL_MAX      : full brightness (exact pass-through)
package video_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  localparam int LVL_W = 4;
  localparam logic [LVL_W-1:0] LVL_MAX = 4'd15;

endpackage

// File: rtl/color_scale.sv
// Combinational three-channel brightness scaler.
//   pix    : packed {R,G,B} input pixel, CH_W bits per channel
//   level  : brightness 0..15; 0 is black, 15 is exact pass-through
//   scaled : packed {R,G,B} scaled pixel
// Only present when SCREEN_FADE_EN is defined (the cut-only build has no scaler).
`ifdef SCREEN_FADE_EN
module color_scale
  import video_pkg::*;
#(
  parameter int CH_W = 4
) (
  input  logic [3*CH_W-1:0] pix,
  input  logic [LVL_W-1:0]  level,
  output logic [3*CH_W-1:0] scaled
);

  // ch*(level+1)/16; with level 15 the factor is 16, so the channel passes unchanged.
  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch,
                                               input logic [LVL_W-1:0] lvl);
    logic [CH_W+4:0] ch_x;
    logic [CH_W+4:0] lv_x;
    logic [CH_W+4:0] prod;
    ch_x = {5'b0, ch};
    lv_x = {{(CH_W+1){1'b0}}, lvl} + (CH_W+5)'(1);
    prod = ch_x * lv_x;
    if (lvl == '0) scale_ch = '0;
    else           scale_ch = prod[CH_W+3:4];
  endfunction

  always_comb begin
    scaled = '0;
    for (int c = 0; c < 3; c++) begin
      scaled[c*CH_W +: CH_W] = scale_ch(pix[c*CH_W +: CH_W], level);
    end
  end

endmodule
`endif

// File: rtl/screen_fader.sv
// Background compositor: selects one of NUM_SCREENS pixel-aligned colour
// sources and changes screen with a frame-synchronous fade through black.
// Build option: SCREEN_FADE_EN. When undefined, a screen change is a plain
// frame-aligned cut and no scaler is built.
//   clk          : pixel clock
//   rst_n        : asynchronous active-low reset
//   screen_color : screen i at [i*COLOR_W +: COLOR_W], {R,G,B}
//   de           : display enable aligned with screen_color
//   frame_start  : one-cycle pulse per frame during blanking
//   sel          : requested screen (values >= NUM_SCREENS ignored)
//   color        : output pixel, 2 cycles after screen_color/de
//   busy         : a screen change is in progress
//   cur_screen   : screen currently shown
module screen_fader
  import video_pkg::*;
#(
  parameter int NUM_SCREENS     = 4,
  parameter int CH_W            = 4,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SCREENS*3*CH_W-1:0]   screen_color,
  input  logic                            de,
  input  logic                            frame_start,
  input  logic [$clog2(NUM_SCREENS)-1:0]  sel,
  output logic [3*CH_W-1:0]               color,
  output logic                            busy,
  output logic [$clog2(NUM_SCREENS)-1:0]  cur_screen
);

  localparam int COLOR_W = 3*CH_W;
  localparam int SEL_W   = $clog2(NUM_SCREENS);
  localparam int STEP_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  logic [SEL_W-1:0]   cur;
  logic [SEL_W-1:0]   pending;
  logic               sel_ok;
  logic [COLOR_W-1:0] pix_mux;

  assign sel_ok     = ({1'b0, sel} < (SEL_W+1)'(NUM_SCREENS));
  assign pix_mux    = screen_color[cur*COLOR_W +: COLOR_W];
  assign cur_screen = cur;

  // Out-of-range requests are dropped so pending always names a real screen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pending <= '0;
    else if (sel_ok) pending <= sel;
  end

  // Stage 1: selected pixel and its enable
  logic [COLOR_W-1:0] pix_p1;
  logic               vld_p1;

  always_ff @(posedge clk) pix_p1 <= pix_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= de;
  end

`ifdef SCREEN_FADE_EN
  fade_state_t       state;
  logic [LVL_W-1:0]  level;
  logic [STEP_W-1:0] step_cnt;
  logic              step_due;
  logic [LVL_W-1:0]  lvl_p1;
  logic [COLOR_W-1:0] scaled;

  function automatic logic [LVL_W-1:0] lvl_dec(input logic [LVL_W-1:0] l);
    lvl_dec = (l == '0) ? l : l - 1'b1;
  endfunction

  function automatic logic [LVL_W-1:0] lvl_inc(input logic [LVL_W-1:0] l);
    lvl_inc = (l == LVL_MAX) ? l : l + 1'b1;
  endfunction

  assign step_due = (step_cnt == STEP_W'(FRAMES_PER_STEP-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      level    <= LVL_MAX;
      step_cnt <= '0;
      cur      <= '0;
      busy     <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          level <= LVL_MAX;
          if (pending != cur) begin
            state    <= FADE_OUT;
            step_cnt <= '0;
          end
        end
        FADE_OUT: begin
          if (level == '0) begin
            state <= SWAP;
          end else if (pending == cur) begin
            // Request withdrawn: climb back from the current level.
            state <= FADE_IN;
          end else if (frame_start) begin
            if (step_due) begin
              level    <= lvl_dec(level);
              step_cnt <= '0;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        SWAP: begin
          cur      <= pending;
          step_cnt <= '0;
          state    <= FADE_IN;
        end
        FADE_IN: begin
          if (level == LVL_MAX) begin
            state <= IDLE;
          end else if (pending != cur) begin
            state    <= FADE_OUT;
            step_cnt <= '0;
          end else if (frame_start) begin
            if (step_due) begin
              level    <= lvl_inc(level);
              step_cnt <= '0;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_p1 <= LVL_MAX;
    else        lvl_p1 <= level;
  end

  color_scale #(.CH_W(CH_W)) u_scale (
    .pix    (pix_p1),
    .level  (lvl_p1),
    .scaled (scaled)
  );

  // Stage 2: scaled pixel, blanked when de was low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) color <= '0;
    else        color <= vld_p1 ? scaled : '0;
  end
`else
  // Cut-only build: switch at the next frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur  <= '0;
      busy <= 1'b0;
    end else begin
      busy <= (pending != cur);
      if (frame_start && (pending != cur)) cur <= pending;
    end
  end

  // Stage 2: pixel, blanked when de was low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) color <= '0;
    else        color <= vld_p1 ? pix_p1 : '0;
  end
`endif

endmodule

// File: tb/tb_screen_fader.sv
// Directed testbench for screen_fader: three screens 0xF80, 0x0AF, 0x777,
// CH_W=4, FRAMES_PER_STEP=2. Covers both the SCREEN_FADE_EN build and the
// cut-only build.
module tb_screen_fader;

  logic        clk;
  logic        rst_n;
  logic [35:0] screen_color;
  logic        de;
  logic        frame_start;
  logic [1:0]  sel;
  logic [11:0] color;
  logic        busy;
  logic [1:0]  cur_screen;

  int n_pass;
  int n_total;

  screen_fader #(
    .NUM_SCREENS     (3),
    .CH_W            (4),
    .FRAMES_PER_STEP (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .screen_color (screen_color),
    .de           (de),
    .frame_start  (frame_start),
    .sel          (sel),
    .color        (color),
    .busy         (busy),
    .cur_screen   (cur_screen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      tick(3);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sel = 2'd0; de = 1'b1; frame_start = 1'b0;
    tick(2);
    n_total++; if (color !== 12'h000) $display("FAIL reset_color: got %h want 000", color); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (cur_screen !== 2'd0) $display("FAIL reset_cur: got %0d want 0", cur_screen); else n_pass++;
    rst_n = 1'b1;
    tick(3);
    n_total++; if (color !== 12'hF80) $display("FAIL steady_color: got %h want F80", color); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL steady_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_de;
    de = 1'b0;
    tick(1);
    n_total++; if (color !== 12'hF80) $display("FAIL de_lat1: got %h want F80", color); else n_pass++;
    tick(1);
    n_total++; if (color !== 12'h000) $display("FAIL de_black: got %h want 000", color); else n_pass++;
    de = 1'b1;
    tick(1);
    n_total++; if (color !== 12'h000) $display("FAIL de_rec1: got %h want 000", color); else n_pass++;
    tick(1);
    n_total++; if (color !== 12'hF80) $display("FAIL de_rec2: got %h want F80", color); else n_pass++;
  endtask

`ifdef SCREEN_FADE_EN
  task automatic test_fade;
    sel = 2'd1;
    tick(3);
    n_total++; if (busy !== 1'b1) $display("FAIL fade_busy_rise: got %b want 1", busy); else n_pass++;
    pulses(2);
    n_total++; if (color !== 12'hE70) $display("FAIL fade_lvl14: got %h want E70", color); else n_pass++;
    n_total++; if (cur_screen !== 2'd0) $display("FAIL fade_cur_old: got %0d want 0", cur_screen); else n_pass++;
    pulses(28);
    n_total++; if (color !== 12'h000) $display("FAIL fade_lvl0: got %h want 000", color); else n_pass++;
    n_total++; if (cur_screen !== 2'd1) $display("FAIL fade_swap: got %0d want 1", cur_screen); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL fade_busy_mid: got %b want 1", busy); else n_pass++;
    pulses(2);
    n_total++; if (color !== 12'h011) $display("FAIL fade_in_lvl1: got %h want 011", color); else n_pass++;
    pulses(28);
    n_total++; if (color !== 12'h0AF) $display("FAIL fade_done_color: got %h want 0AF", color); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL fade_done_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reverse;
    sel = 2'd0;
    tick(3);
    pulses(14);
    n_total++; if (color !== 12'h058) $display("FAIL rev_lvl8: got %h want 058", color); else n_pass++;
    sel = 2'd1;
    tick(3);
    n_total++; if (busy !== 1'b1) $display("FAIL rev_busy: got %b want 1", busy); else n_pass++;
    n_total++; if (cur_screen !== 2'd1) $display("FAIL rev_noswap: got %0d want 1", cur_screen); else n_pass++;
    pulses(13);
    n_total++; if (color !== 12'h09E) $display("FAIL rev_lvl14: got %h want 09E", color); else n_pass++;
    pulses(1);
    n_total++; if (color !== 12'h0AF) $display("FAIL rev_done_color: got %h want 0AF", color); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rev_done_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid;
    sel = 2'd2;
    tick(3);
    pulses(4);
    n_total++; if (color !== 12'h08D) $display("FAIL mid_lvl13: got %h want 08D", color); else n_pass++;
    rst_n = 1'b0;
    sel = 2'd0;
    #1;
    n_total++; if (color !== 12'h000) $display("FAIL mid_rst_color: got %h want 000", color); else n_pass++;
    n_total++; if (cur_screen !== 2'd0) $display("FAIL mid_rst_cur: got %0d want 0", cur_screen); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    n_total++; if (color !== 12'hF80) $display("FAIL mid_rel_color: got %h want F80", color); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_rel_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_simul;
    sel = 2'd1;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(3);
    pulses(1);
    n_total++; if (color !== 12'hF80) $display("FAIL simul_uncounted: got %h want F80", color); else n_pass++;
    pulses(1);
    n_total++; if (color !== 12'hE70) $display("FAIL simul_step: got %h want E70", color); else n_pass++;
  endtask
`else
  task automatic test_cut;
    sel = 2'd1;
    tick(3);
    n_total++; if (busy !== 1'b1) $display("FAIL cut_busy_rise: got %b want 1", busy); else n_pass++;
    n_total++; if (cur_screen !== 2'd0) $display("FAIL cut_wait_cur: got %0d want 0", cur_screen); else n_pass++;
    n_total++; if (color !== 12'hF80) $display("FAIL cut_wait_color: got %h want F80", color); else n_pass++;
    pulses(1);
    n_total++; if (cur_screen !== 2'd1) $display("FAIL cut_cur: got %0d want 1", cur_screen); else n_pass++;
    n_total++; if (color !== 12'h0AF) $display("FAIL cut_color: got %h want 0AF", color); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL cut_busy_fall: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_simul;
    sel = 2'd2;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(3);
    n_total++; if (cur_screen !== 2'd1) $display("FAIL simul_nocut: got %0d want 1", cur_screen); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL simul_busy: got %b want 1", busy); else n_pass++;
    pulses(1);
    n_total++; if (cur_screen !== 2'd2) $display("FAIL simul_cut: got %0d want 2", cur_screen); else n_pass++;
    n_total++; if (color !== 12'h777) $display("FAIL simul_color: got %h want 777", color); else n_pass++;
  endtask

  task automatic test_reset_mid;
    sel = 2'd0;
    tick(3);
    n_total++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (color !== 12'h000) $display("FAIL mid_rst_color: got %h want 000", color); else n_pass++;
    n_total++; if (cur_screen !== 2'd0) $display("FAIL mid_rst_cur: got %0d want 0", cur_screen); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    n_total++; if (color !== 12'hF80) $display("FAIL mid_rel_color: got %h want F80", color); else n_pass++;
  endtask
`endif

  task automatic test_invalid;
    sel = 2'd3;
    tick(3);
    pulses(1);
    n_total++; if (busy !== 1'b0) $display("FAIL inv_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (cur_screen !== 2'd1) $display("FAIL inv_cur: got %0d want 1", cur_screen); else n_pass++;
    n_total++; if (color !== 12'h0AF) $display("FAIL inv_color: got %h want 0AF", color); else n_pass++;
    sel = 2'd1;
    tick(2);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    screen_color = {12'h777, 12'h0AF, 12'hF80};
    rst_n = 1'b0;
    de = 1'b1;
    frame_start = 1'b0;
    sel = 2'd0;
    test_reset;
    test_de;
`ifdef SCREEN_FADE_EN
    test_fade;
    test_reverse;
    test_invalid;
    test_reset_mid;
    test_simul;
`else
    test_cut;
    test_invalid;
    test_simul;
    test_reset_mid;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/screen_fader.md
# screen_fader

Parametrised background compositor for the video path. Selects one of `NUM_SCREENS` full-screen colour sources, which the per-screen image ROMs feed pixel-aligned. On a screen change it performs a frame-synchronous fade-through-black: the old screen fades out, then the new screen fades in. The result drives the VGA colour output stage.

## Interface
Parameters:
- `NUM_SCREENS`, 4: number of selectable screens (2..16).
- `CH_W`, 4: bits per colour channel; `COLOR_W = 3*CH_W`, packed {R,G,B}.
- `FRAMES_PER_STEP`, 2: `frame_start` pulses per brightness step (≥1).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: pixel clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `screen_color`  in  `NUM_SCREENS*COLOR_W`: screen i occupies bits [i*COLOR_W +: COLOR_W].
- `de`  in  1: display enable, aligned with `screen_color`.
- `frame_start`  in  1: one-cycle pulse per frame, issued during blanking.
- `sel`  in  `$clog2(NUM_SCREENS)`: requested screen, level-sensitive.
- `color`  out  `COLOR_W`: output pixel.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `cur_screen`  out  `$clog2(NUM_SCREENS)`: screen currently shown.

## Operation
- Registers:
  - `cur`: current screen.
  - `pending`: last valid `sel`. A `sel` value ≥ `NUM_SCREENS` is ignored and `pending` holds.
  - `level`: brightness, 4 bits, 0..15.
  - `step_cnt`: counts `frame_start` pulses toward `FRAMES_PER_STEP`.
- Scaling, per channel:
  - `level==0` → 0.
  - Otherwise `(ch*(level+1))>>4`, with a product width of `CH_W+5`.
  - `level==15` is exact pass-through.
- FSM states: IDLE, FADE_OUT, SWAP, FADE_IN.
  - IDLE: `level=15`. If `pending!=cur`, go to FADE_OUT and clear `step_cnt`.
  - FADE_OUT: each `frame_start` increments `step_cnt`. When `step_cnt` reaches `FRAMES_PER_STEP-1`, the next `frame_start` decrements `level` and clears `step_cnt`. At `level==0`, go to SWAP. If `pending==cur` while `level>0`, reverse to FADE_IN from the current level.
  - SWAP: lasts one cycle. `cur<=pending`, then go to FADE_IN. This holds even if `pending` equals the old `cur`.
  - FADE_IN: same stepping as FADE_OUT, but `level` increments. At `level==15`, go to IDLE. If `pending!=cur`, reverse to FADE_OUT from the current level and clear `step_cnt`.
- `level` saturates and never wraps past 0 or 15.
- Simultaneous events:
  - A `sel` change in the same cycle as `frame_start` in IDLE starts the fade; that `frame_start` is not counted.
  - `frame_start` during SWAP is ignored.
- `de` low forces `color` to 0. The forced black is pipelined with the pixel.

## Timing
- Reset values: `color=0`, `busy=0`, `cur_screen=0`, `cur=0`, `pending=0`, `level=15`, `step_cnt=0`, state IDLE.
- Reset mid-fade aborts immediately to these values.
- Pixel latency is 2 cycles, `screen_color`/`de` → `color`:
  - Stage 1 registers the mux output, `de` and `level`.
  - Stage 2 registers the scaled result.
- A `level` update applies starting with pixels entering stage 1 on the cycle after the `frame_start` that caused it.
- `busy` is registered and rises the cycle after the state leaves IDLE.
- A full uninterrupted transition lasts `15*FRAMES_PER_STEP` frames out, plus `15*FRAMES_PER_STEP` frames in, plus one SWAP cycle.

## Configuration
- `SCREEN_FADE_EN` defined: fade behaviour as above.
- `SCREEN_FADE_EN` undefined:
  - No scaler and no FADE states; `level` is fixed at 15.
  - On `pending!=cur`, `cur<=pending` at the next `frame_start`, giving a frame-aligned cut.
  - `busy` is high from the request until that cut.
  - Pixel latency remains 2 cycles; the stage 2 register is kept.

## Structure
- Shared package `video_pkg`:
  - state enum `fade_state_t` (IDLE, FADE_OUT, SWAP, FADE_IN);
  - `LVL_W=4`;
  - `LVL_MAX=15`.
- Sub-module `color_scale`: combinational per-pixel, three-channel scaler parameterised by `CH_W`, instantiated once between stage 1 and stage 2.

## Test plan
All scenarios use `NUM_SCREENS=3`, `CH_W=4`, `FRAMES_PER_STEP=2`, with screen colours 0xF80, 0x0AF, 0x777.
- Reset then steady `sel=0`, `de=1` → `color=0xF80` two cycles after input, `busy=0`.
- `sel` 0→1 → `busy` rises; after 2 `frame_start` pulses, level 14 gives `color=0xE70`. Level reaches 0 (`color=0x000`) after 30 pulses. SWAP sets `cur_screen=1`. After 30 more pulses, `color=0x0AF`, `busy=0`.
- `sel` 0→1, then back to 0 at level 8 → reverses to FADE_IN on screen 0 with no SWAP, and reaches 0xF80 after 14 more pulses.
- `sel=3` (invalid) in IDLE → ignored: `pending` is unchanged and `busy` stays 0.
- Assert `rst_n` low mid-FADE_OUT → immediately `color=0`, `cur_screen=0`. After release, screen 0 shows at full brightness.
- `de=0` during full brightness → `color=0x000` with 2-cycle alignment; recovers when `de` returns high.
